// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
//  Module      : icache_responder
//  Description : Direct-mapped, one-word-per-frame instruction cache that
//                answers the datapath fetch port (imemREN/imemaddr ->
//                ihit/imemload) with zero-cycle hits and refills misses from
//                the memory controller over a blocking iREN/iwait handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK        in   1   clock, all state changes on rising edge
//    RST        in   1   synchronous active-high reset
//    imemREN    in   1   datapath fetch request
//    imemaddr   in  32   fetch byte address (bits [1:0] ignored)
//    ihit       out  1   requested word valid this cycle
//    imemload   out 32   instruction word, zero unless ihit
//    flush      in   1   invalidate every frame
//    iREN       out  1   memory read request
//    iaddr      out 32   memory read address (word aligned)
//    iwait      in   1   memory busy; data taken when iREN=1 and iwait=0
//    iload      in  32   memory read data
//  Optional (macro ICACHE_STATS_EN)
//    hit_count  out 32   saturating count of cycles with ihit=1
//    miss_count out 32   saturating count of IDLE->FETCH transitions
// ============================================================================
module icache_responder #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [SETS-1:0]  valid_q, valid_d;
    logic [31:0]      miss_addr_q, miss_addr_d;
    // Set when a flush lands while a refill is outstanding, so that the
    // refill still completes but never marks its frame valid.
    logic             flushed_q, flushed_d;

    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] miss_idx;
    logic             lookup_hit;
    logic             hit_w;
    logic             refill_done;

    assign req_tag     = imemaddr[31:IDX_W+2];
    assign req_idx     = imemaddr[IDX_W+1:2];
    assign miss_tag    = miss_addr_q[31:IDX_W+2];
    assign miss_idx    = miss_addr_q[IDX_W+1:2];
    assign lookup_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // A flush in IDLE suppresses the hit in that same cycle.
    assign hit_w       = !RST && imemREN && (state_q == S_IDLE) && !flush && lookup_hit;
    assign refill_done = (state_q == S_FETCH) && !iwait;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            flushed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
            flushed_q   <= flushed_d;
        end
    end

    // Tag/data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (!RST && refill_done) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_addr_d = miss_addr_q;
        flushed_d   = flushed_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end
                if (imemREN && !hit_w) begin
                    state_d     = S_FETCH;
                    // Masking the whole address keeps the latch word aligned.
                    miss_addr_d = imemaddr & 32'hFFFF_FFFC;
                    flushed_d   = 1'b0;
                end
            end
            S_FETCH: begin
                if (flush) begin
                    valid_d   = '0;
                    flushed_d = 1'b1;
                end
                if (!iwait) begin
                    state_d = S_IDLE;
                    if (!flush && !flushed_q) begin
                        valid_d[miss_idx] = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: memory side depends only on state and the miss latch.
    // ------------------------------------------------------------------
    always_comb begin
        ihit     = hit_w;
        imemload = hit_w ? data_q[req_idx] : 32'h0;
        iREN     = (state_q == S_FETCH);
        iaddr    = (state_q == S_FETCH) ? miss_addr_q : 32'h0;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (hit_w && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if ((state_q == S_IDLE) && (state_d == S_FETCH) &&
                (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_responder
//  Description : Self-checking bench for icache_responder. A word-address
//                level model of the cache is compared against the DUT on
//                every falling edge; directed sequences add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_responder;

    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 CLK = ~CLK;

    icache_responder #(.SETS(SETS)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .flush    (flush),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // Memory contents: fixed word at 0x40, hashed pattern elsewhere.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2001_0005;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    assign iload = memf(iaddr);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: each frame remembers which word address it holds.
    // ------------------------------------------------------------------
    logic        m_live = 1'b0;
    logic        m_valid [SETS];
    logic [31:0] m_word  [SETS];
    logic        m_fetch;
    logic [31:0] m_addr;
    logic        m_flushed;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    always @(negedge CLK) begin
        logic [31:0] wa;
        int          ix;
        int          mx;
        logic        e_hit;
        wa    = imemaddr & 32'hFFFF_FFFC;
        ix    = int'((imemaddr >> 2) % SETS);
        e_hit = 1'b0;
        if (m_live) begin
            e_hit = !RST && imemREN && !m_fetch && !flush && m_valid[ix] && (m_word[ix] == wa);
            check("model_ihit", {31'b0, ihit}, {31'b0, e_hit});
            check("model_imemload", imemload, e_hit ? memf(wa) : 32'h0);
            check("model_iREN", {31'b0, iREN}, {31'b0, m_fetch});
            check("model_iaddr", iaddr, m_fetch ? m_addr : 32'h0);
`ifdef ICACHE_STATS_EN
            check("model_hit_count", hit_count, m_hits);
            check("model_miss_count", miss_count, m_misses);
`endif
        end
        if (RST) begin
            m_live    = 1'b1;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_fetch   = 1'b0;
            m_addr    = 32'h0;
            m_flushed = 1'b0;
            m_hits    = 32'h0;
            m_misses  = 32'h0;
        end else if (m_live) begin
            if (e_hit) m_hits = m_hits + 1;
            if (!m_fetch) begin
                if (flush) foreach (m_valid[i]) m_valid[i] = 1'b0;
                if (imemREN && !e_hit) begin
                    m_fetch   = 1'b1;
                    m_addr    = wa;
                    m_flushed = 1'b0;
                    m_misses  = m_misses + 1;
                end
            end else begin
                if (flush) begin
                    foreach (m_valid[i]) m_valid[i] = 1'b0;
                    m_flushed = 1'b1;
                end
                if (!iwait) begin
                    if (!m_flushed) begin
                        mx          = int'((m_addr >> 2) % SETS);
                        m_valid[mx] = 1'b1;
                        m_word[mx]  = m_addr;
                    end
                    m_fetch = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 unit after the rising edge, literal
    // checks happen 3 units after it.
    // ------------------------------------------------------------------
    task automatic step(input logic ren, input logic [31:0] a, input logic fl, input logic w);
        @(posedge CLK);
        #1;
        imemREN  = ren;
        imemaddr = a;
        flush    = fl;
        iwait    = w;
        #2;
    endtask

    task automatic wait_hit(input logic [31:0] a, input string nm);
        int k;
        k = 0;
        while (!ihit && k < 10) begin
            step(1'b1, a, 1'b0, 1'b0);
            k++;
        end
        check(nm, {31'b0, ihit}, 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        imemREN = 1'b0;
        flush = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #2;
    endtask

    initial begin
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        flush    = 1'b0;
        iwait    = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        #2;
        check("reset_ihit", {31'b0, ihit}, 32'd0);
        check("reset_iREN", {31'b0, iREN}, 32'd0);
        check("reset_iaddr", iaddr, 32'h0);
        check("reset_imemload", imemload, 32'h0);

        // Cold miss on 0x40 with two wait cycles.
        step(1'b1, 32'h40, 1'b0, 1'b1);
        check("cold_idle_ihit", {31'b0, ihit}, 32'd0);
        check("cold_idle_iREN", {31'b0, iREN}, 32'd0);
        step(1'b1, 32'h40, 1'b0, 1'b1);
        check("cold_w1_iREN", {31'b0, iREN}, 32'd1);
        check("cold_w1_iaddr", iaddr, 32'h40);
        check("cold_w1_ihit", {31'b0, ihit}, 32'd0);
        step(1'b1, 32'h40, 1'b0, 1'b1);
        check("cold_w2_iaddr", iaddr, 32'h40);
        step(1'b1, 32'h40, 1'b0, 1'b0);
        check("cold_acc_iREN", {31'b0, iREN}, 32'd1);
        check("cold_acc_iaddr", iaddr, 32'h40);
        check("cold_acc_ihit", {31'b0, ihit}, 32'd0);
        step(1'b1, 32'h40, 1'b0, 1'b1);
        check("cold_hit_ihit", {31'b0, ihit}, 32'd1);
        check("cold_hit_data", imemload, 32'h2001_0005);
        check("cold_hit_iREN", {31'b0, iREN}, 32'd0);
        // Hit after fill.
        step(1'b1, 32'h40, 1'b0, 1'b1);
        check("rehit_ihit", {31'b0, ihit}, 32'd1);
        check("rehit_iREN", {31'b0, iREN}, 32'd0);

        // Conflict eviction: 0x0 and 0x40 share index 0.
        step(1'b1, 32'h0, 1'b0, 1'b0);
        check("conf_first_miss", {31'b0, ihit}, 32'd0);
        wait_hit(32'h0, "conf_fill0");
        step(1'b1, 32'h40, 1'b0, 1'b0);
        check("conf_evict_miss", {31'b0, ihit}, 32'd0);
        wait_hit(32'h40, "conf_fill40");
        step(1'b1, 32'h0, 1'b0, 1'b0);
        check("conf_remiss", {31'b0, ihit}, 32'd0);
        wait_hit(32'h0, "conf_refill0");

        // Redirect mid-fetch.
        step(1'b1, 32'h100, 1'b0, 1'b1);
        check("redir_miss", {31'b0, ihit}, 32'd0);
        step(1'b1, 32'h200, 1'b0, 1'b1);
        check("redir_hold_iaddr", iaddr, 32'h100);
        step(1'b1, 32'h200, 1'b0, 0);
        check("redir_acc_iaddr", iaddr, 32'h100);
        step(1'b1, 32'h200, 1'b0, 1'b0);
        check("redir_second_miss", {31'b0, ihit}, 32'd0);
        step(1'b1, 32'h200, 1'b0, 1'b0);
        check("redir_new_iaddr", iaddr, 32'h200);
        step(1'b1, 32'h200, 1'b0, 1'b0);
        check("redir_hit", {31'b0, ihit}, 32'd1);
        check("redir_data", imemload, memf(32'h200));

        // Flush during FETCH.
        step(1'b1, 32'h80, 1'b0, 1'b1);
        step(1'b1, 32'h80, 1'b1, 1'b1);
        check("flush_fetch_iaddr", iaddr, 32'h80);
        step(1'b1, 32'h80, 1'b0, 1'b0);
        step(1'b1, 32'h80, 1'b0, 1'b1);
        check("flush_remiss", {31'b0, ihit}, 32'd0);
        step(1'b0, 32'h80, 1'b0, 1'b0);

        // Halt: imemREN drops while refilling.
        step(1'b1, 32'hC4, 1'b0, 1'b1);
        step(1'b0, 32'hC4, 1'b0, 1'b1);
        step(1'b0, 32'hC4, 1'b0, 1'b0);
        step(1'b0, 32'hC4, 1'b0, 1'b1);
        check("halt_ihit", {31'b0, ihit}, 32'd0);
        check("halt_iREN", {31'b0, iREN}, 32'd0);

`ifdef ICACHE_STATS_EN
        pulse_reset();
        step(1'b1, 32'h40, 1'b0, 1'b0);
        step(1'b1, 32'h40, 1'b0, 1'b0);
        repeat (5) step(1'b1, 32'h40, 1'b0, 1'b0);
        step(1'b0, 32'h40, 1'b0, 1'b0);
        check("stats_miss", miss_count, 32'd1);
        check("stats_hit", hit_count, 32'd5);
        pulse_reset();
        check("stats_rst_miss", miss_count, 32'd0);
        check("stats_rst_hit", hit_count, 32'd0);
`endif

        // Randomized traffic over a small address pool to force reuse.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            a = ({28'h0, 4'($urandom_range(0, 3))} << 6) |
                ({28'h0, 4'($urandom_range(0, SETS - 1))} << 2) |
                32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = a | ($urandom & 32'hF000_0000);
            @(posedge CLK);
            #1;
            RST      = ($urandom_range(0, 299) == 0);
            imemREN  = ($urandom_range(0, 99) < 85);
            imemaddr = a;
            flush    = ($urandom_range(0, 99) < 3);
            iwait    = ($urandom_range(0, 1) == 1);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        imemREN = 1'b0;
        flush = 1'b0;
        repeat (3) @(posedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
